// File: rtl/sample_ctrl.sv
// Scheduled ADC -> offset/gain -> DAC sample sequencer, one sample per CLK_DIV clocks.
// Optional build macro GAIN_SAT_EN: clamp the scaled result to -512..511 instead of wrapping.
module sample_ctrl #(
   parameter int unsigned CLK_DIV     = 1000,
   parameter int unsigned ADC_TIMEOUT = 64,
   parameter logic [9:0]  ADC_OFFSET  = 10'h181,
   parameter logic [9:0]  DAC_OFFSET  = 10'h200
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] gain_sel,
   input  logic       clr_err,
   output logic       adc_start,
   input  logic       adc_done,
   input  logic [9:0] adc_data,
   output logic [9:0] dac_data,
   output logic       dac_load,
   output logic       busy,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int unsigned TW        = (ADC_TIMEOUT < 2) ? 1 : $clog2(ADC_TIMEOUT);
   localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT,
      S_CALC,
      S_LOAD
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [15:0]   r_tick_cnt;
   logic [TW-1:0] r_to_cnt;
   logic [9:0]    r_adc;
   logic [1:0]    r_gain;
   logic [9:0]    r_dac;
   logic          r_err_timeout;
   logic          r_err_overrun;

   logic          w_tick;
   logic          w_capture;
   logic          w_to_hit;
   logic          w_to_clr;
   logic          w_to_inc;
   logic          w_overrun;
   logic [9:0]    w_x;
   logic [12:0]   w_y;
   logic [9:0]    w_r;
   logic [9:0]    w_dac_next;

   assign w_tick    = enable && (r_tick_cnt == TICK_LAST);
   assign w_overrun = w_tick && (r_state != S_IDLE);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (!enable || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_to_hit     = 1'b0;
      w_to_clr     = 1'b0;
      w_to_inc     = 1'b0;
      case (r_state)
         S_IDLE: if (w_tick) w_state_next = S_CONV;
         S_CONV: begin
            w_to_clr     = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (adc_done) begin
               w_capture    = 1'b1;
               w_state_next = S_CALC;
            end else if (r_to_cnt == TO_LAST) begin
               w_to_hit     = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_to_inc     = 1'b1;
            end
         end
         S_CALC:  w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (w_to_clr) begin
         r_to_cnt <= '0;
      end else if (w_to_inc) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   // Gain is latched with the sample so later gain_sel changes cannot affect it.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_adc  <= '0;
         r_gain <= '0;
      end else if (w_capture) begin
         r_adc  <= adc_data;
         r_gain <= gain_sel;
      end
   end

   assign w_x = adc_data_diff(r_adc);
   assign w_y = {{3{w_x[9]}}, w_x} << r_gain;

   function automatic logic [9:0] adc_data_diff(input logic [9:0] raw);
      return raw - ADC_OFFSET;
   endfunction

`ifdef GAIN_SAT_EN
   always_comb begin
      w_r = w_y[9:0];
      if (!w_y[12] && (w_y[11:9] != 3'b000)) begin
         w_r = 10'h1FF;
      end else if (w_y[12] && (w_y[11:9] != 3'b111)) begin
         w_r = 10'h200;
      end
   end
`else
   assign w_r = w_y[9:0];
`endif

   assign w_dac_next = w_r + DAC_OFFSET;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_dac <= DAC_OFFSET;
      end else if (r_state == S_CALC) begin
         r_dac <= w_dac_next;
      end
   end

   // A new error event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         r_err_timeout <= (r_err_timeout && !clr_err) || w_to_hit;
         r_err_overrun <= (r_err_overrun && !clr_err) || w_overrun;
      end
   end

   assign adc_start   = (r_state == S_CONV);
   assign dac_load    = (r_state == S_LOAD);
   assign busy        = (r_state != S_IDLE);
   assign dac_data    = r_dac;
   assign err_timeout = r_err_timeout;
   assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_sample_ctrl.sv
// Directed bench for sample_ctrl with CLK_DIV=8, ADC_TIMEOUT=64; expectations follow GAIN_SAT_EN.
module tb_sample_ctrl;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] gain_sel;
   logic       clr_err;
   logic       adc_start;
   logic       adc_done;
   logic [9:0] adc_data;
   logic [9:0] dac_data;
   logic       dac_load;
   logic       busy;
   logic       err_timeout;
   logic       err_overrun;

   int n_vec    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int t_last   = 0;
   logic [9:0] exp_last;

`ifdef GAIN_SAT_EN
   localparam logic [9:0] EXP_POS_OVF = 10'h3FF;
   localparam logic [9:0] EXP_NEG_OVF = 10'h000;
`else
   localparam logic [9:0] EXP_POS_OVF = 10'h200;
   localparam logic [9:0] EXP_NEG_OVF = 10'h200;
`endif

   sample_ctrl #(
      .CLK_DIV     (8),
      .ADC_TIMEOUT (64),
      .ADC_OFFSET  (10'h181),
      .DAC_OFFSET  (10'h200)
   ) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .enable      (enable),
      .gain_sel    (gain_sel),
      .clr_err     (clr_err),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_data    (adc_data),
      .dac_data    (dac_data),
      .dac_load    (dac_load),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input int exp_gap);
      int n;
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (!adc_start && n < 200);
      check("start_gap", cyc - t_last, exp_gap);
      t_last = cyc;
   endtask

   task automatic sample(input int delay, input logic [9:0] data, input logic [1:0] gain,
                         input logic [9:0] exp_dac, input int exp_gap, input bit drop_en);
      wait_start(exp_gap);
      if (drop_en) enable = 1'b0;
      adc_data = data;
      gain_sel = gain;
      repeat (delay) @(negedge sysclk);
      adc_done = 1'b1;
      @(negedge sysclk);
      adc_done = 1'b0;
      adc_data = ~data;
      gain_sel = ~gain;
      check("load_early", dac_load, 1'b0);
      @(negedge sysclk);
      check("dac_load", dac_load, 1'b1);
      check("dac_data", dac_data, exp_dac);
      @(negedge sysclk);
      check("load_end", dac_load, 1'b0);
      exp_last = exp_dac;
      $display("sample adc=%h gain=%0d delay=%0d dac=%h expected=%h", data, gain, delay,
               dac_data, exp_dac);
   endtask

   initial begin
      int loads;
      int starts;
      rst_n    = 1'b0;
      enable   = 1'b1;
      gain_sel = 2'd0;
      clr_err  = 1'b0;
      adc_done = 1'b0;
      adc_data = 10'h000;
      exp_last = 10'h200;

      repeat (2) @(negedge sysclk);
      check("rst_adc_start", adc_start, 1'b0);
      check("rst_dac_load", dac_load, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err_to", err_timeout, 1'b0);
      check("rst_err_ov", err_overrun, 1'b0);
      check("rst_dac_data", dac_data, 10'h200);

      rst_n  = 1'b1;
      t_last = cyc;

      // Baseline and gain vectors
      sample(3, 10'h181, 2'd2, 10'h200, 8, 1'b0);
      sample(3, 10'h181, 2'd2, 10'h200, 8, 1'b0);
      sample(3, 10'h191, 2'd2, 10'h240, 8, 1'b0);
      sample(3, 10'h191, 2'd0, 10'h210, 8, 1'b0);
      sample(3, 10'h191, 2'd3, 10'h280, 8, 1'b0);
      sample(3, 10'h171, 2'd1, 10'h1E0, 8, 1'b0);
      sample(3, 10'h281, 2'd2, EXP_POS_OVF, 8, 1'b0);
      sample(3, 10'h081, 2'd2, EXP_NEG_OVF, 8, 1'b0);
      check("no_err_ov", err_overrun, 1'b0);
      check("no_err_to", err_timeout, 1'b0);

      // Overrun: slow ADC swallows one tick
      sample(10, 10'h191, 2'd1, 10'h220, 8, 1'b0);
      check("err_overrun", err_overrun, 1'b1);
      sample(3, 10'h191, 2'd2, 10'h240, 16, 1'b0);
      clr_err = 1'b1;
      @(negedge sysclk);
      clr_err = 1'b0;
      check("clr_overrun", err_overrun, 1'b0);

      // Timeout: ADC never answers
      wait_start(8);
      loads = 0;
      repeat (63) begin
         @(negedge sysclk);
         if (dac_load) loads++;
      end
      @(negedge sysclk);
      if (dac_load) loads++;
      check("to_not_yet", err_timeout, 1'b0);
      check("to_busy", busy, 1'b1);
      @(negedge sysclk);
      if (dac_load) loads++;
      check("err_timeout", err_timeout, 1'b1);
      check("to_idle", busy, 1'b0);
      check("to_dac_hold", dac_data, exp_last);
      check("to_no_load", loads, 0);
      check("to_overrun", err_overrun, 1'b1);
      sample(3, 10'h191, 2'd3, 10'h280, 72, 1'b0);

      // Reset in WAIT
      wait_start(8);
      repeat (2) @(negedge sysclk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_start", adc_start, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_load", dac_load, 1'b0);
      check("mid_rst_dac", dac_data, 10'h200);
      check("mid_rst_err_to", err_timeout, 1'b0);
      check("mid_rst_err_ov", err_overrun, 1'b0);
      @(negedge sysclk);
      rst_n  = 1'b1;
      t_last = cyc;
      sample(3, 10'h191, 2'd0, 10'h210, 8, 1'b0);

      // Enable dropped mid-sample: sample completes, no further ticks
      sample(3, 10'h171, 2'd2, 10'h1C0, 8, 1'b1);
      starts = 0;
      repeat (30) begin
         @(negedge sysclk);
         if (adc_start) starts++;
      end
      check("disabled_starts", starts, 0);
      check("disabled_busy", busy, 1'b0);
      enable = 1'b1;
      t_last = cyc;
      sample(3, 10'h181, 2'd1, 10'h200, 8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sample_ctrl.md
Name: sample_ctrl

Overview:
- Sequences one ADC -> process -> DAC sample cycle per programmable sample period. Runs from the system clock.
- Issues the ADC conversion start and waits for conversion done. Then removes the ADC offset, applies a selectable power-of-two gain, re-biases by the DAC offset, and strobes the DAC load.
- Sits between the ADC/DAC interface pins and the processing datapath. It replaces free-running every-clock sampling with a scheduled, handshaked sample flow.

Parameters:
- CLK_DIV, 1000: sysclk cycles per sample period; legal range 8..65535.
- ADC_TIMEOUT, 64: max sysclk cycles to wait for adc_done after adc_start.
- ADC_OFFSET, 10'h181: ADC zero code, subtracted from the raw sample.
- DAC_OFFSET, 10'h200: DAC mid-scale code, added to the result.

Ports:
- sysclk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run sample scheduler when high.
- gain_sel  in  2  gain shift: 0=x1, 1=x2, 2=x4, 3=x8.
- clr_err  in  1  synchronous clear of sticky error flags.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  ADC conversion complete, level or pulse.
- adc_data  in  10  raw ADC sample, valid when adc_done=1.
- dac_data  out  10  registered DAC code.
- dac_load  out  1  one-cycle DAC load strobe, coincident with new dac_data.
- busy  out  1  high whenever FSM is not IDLE.
- err_timeout  out  1  sticky: ADC failed to respond within ADC_TIMEOUT.
- err_overrun  out  1  sticky: sample tick arrived while FSM was not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, tick counter=0, timeout counter=0.
  - adc_start=0, dac_load=0, busy=0, err_timeout=0, err_overrun=0.
  - dac_data=DAC_OFFSET (mid-scale output).
- Tick counter:
  - While enable=1, counts 0..CLK_DIV-1 and wraps.
  - tick=1 for the one cycle where the count equals CLK_DIV-1.
  - While enable=0, the counter is held at 0 and no ticks are generated.
- FSM states: IDLE, CONV, WAIT, CALC, LOAD.
  - IDLE: on tick -> CONV.
  - CONV: adc_start=1 for exactly this cycle; timeout counter cleared -> WAIT.
  - WAIT: on adc_done=1, capture adc_data and gain_sel -> CALC.
    - Otherwise increment the timeout counter.
    - When the counter reaches ADC_TIMEOUT, set err_timeout -> IDLE. No dac_load; dac_data unchanged.
  - CALC: compute the result into dac_data -> LOAD.
  - LOAD: dac_load=1 for this cycle only -> IDLE.
- Latency: adc_done sampled at edge E gives dac_data updated and dac_load high in the cycle after edge E+1, i.e. two clocks after capture.
- Arithmetic:
  - x = adc_data - ADC_OFFSET, 10-bit two's complement (-512..511).
  - y = x << gain_sel, computed at 13 bits signed.
  - r = y, reduced to 10-bit signed per the Optional Feature.
  - dac_data = r + DAC_OFFSET, modulo 1024.
- Boundary conditions:
  - tick while FSM is not IDLE: tick dropped, err_overrun set. The in-flight sample completes normally.
  - enable deasserted mid-sample: the current sample completes through LOAD; no new ticks follow.
  - adc_done already high in CONV: ignored; only sampled in WAIT.
  - gain_sel change mid-sample: no effect; the value captured in WAIT is used.
  - clr_err together with a new error event: the error wins and the flag stays set.
  - Reset mid-operation: immediate return to reset values.

Optional Feature:
- GAIN_SAT_EN defined:
  - r is clamped to -512..511.
  - e.g. y=1024 -> r=511; y=-1024 -> r=-512.
- GAIN_SAT_EN undefined:
  - r = y[9:0], wrap-around with no clamp. This matches plain multiply-and-truncate.

Test Plan:
- Baseline: CLK_DIV=8, enable=1, ADC answers adc_done 3 cycles after adc_start, adc_data=0x181, gain_sel=2 -> adc_start every 8 cycles; dac_load 2 cycles after adc_done; dac_data=0x200.
- Gain: adc_data=0x191 (x=16), gain_sel=2 -> dac_data=0x240. Same input with gain_sel=0 -> 0x210.
- Overflow: adc_data=0x281 (x=256), gain_sel=2 -> dac_data=0x3FF with GAIN_SAT_EN, 0x200 without. adc_data=0x081 (x=-256), gain_sel=2 -> 0x000 with GAIN_SAT_EN, 0x200 without.
- Timeout: adc_done held 0, ADC_TIMEOUT=64 -> err_timeout set 64 cycles after WAIT entry; no dac_load; dac_data unchanged; next tick starts a new CONV. clr_err pulse -> err_timeout=0.
- Overrun: CLK_DIV=8, ADC answers after 10 cycles -> err_overrun set; one tick dropped; sample still loads correctly.
- Reset: assert rst_n=0 during WAIT -> outputs immediately at reset values, dac_data=0x200. After release, the first adc_start occurs CLK_DIV cycles later.
